// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit with a two-entry FIFO toward decode
// Fetches from a combinational imem at PC, queues {pc,instr,fault} entries, handles redirects.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
);

  localparam int          CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic {S_FETCH, S_HALT} state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } entry_t;

  state_t            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  cnt_after;
  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  entry_t            new_entry;
  entry_t            fault_entry;
  logic              fetch_en;
  logic              enq;
  logic              deq;
  logic              misaligned;

  assign imem_addr  = pc_q;
  assign out_valid  = (count_q != '0);
  assign deq        = out_valid & out_ready;
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  assign new_entry   = '{pc: pc_q, instr: imem_instr, exc_en: imem_exc_en,
                         exc_code: imem_exc_code, exc_val: imem_exc_val};
  assign fault_entry = '{pc: redirect_pc, instr: NOP, exc_en: 1'b1,
                         exc_code: 4'd0, exc_val: redirect_pc};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: redirect wins; a faulting fetch parks the unit until the next redirect
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = misaligned ? S_HALT : S_FETCH;
    end else if (enq && imem_exc_en) begin
      state_d = S_HALT;
    end
  end

  // State outputs
  always_comb begin
    fetch_en = (state_q == S_FETCH);
    enq      = fetch_en && !redirect_valid &&
               ((count_q < CNT_W'(DEPTH)) || deq);
  end

  // Buffer is a shift pair: head feeds decode, tail refills head on dequeue
  always_comb begin
    pc_d      = pc_q;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_after = count_q - CNT_W'(deq);
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (misaligned) begin
        head_d  = fault_entry;
        count_d = CNT_W'(1);
      end else begin
        count_d = '0;
      end
    end else begin
      if (deq) begin
        head_d = tail_q;
      end
      if (enq) begin
        if (cnt_after == '0) begin
          head_d = new_entry;
        end else begin
          tail_d = new_entry;
        end
        count_d = cnt_after + CNT_W'(1);
        if (!imem_exc_en) begin
          pc_d = pc_q + 64'd4;
        end
      end else begin
        count_d = cnt_after;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Empty buffer presents a NOP with no fault
  always_comb begin
    out_pc       = 64'd0;
    out_instr    = NOP;
    out_exc_en   = 1'b0;
    out_exc_code = 4'd0;
    out_exc_val  = 64'd0;
    if (out_valid) begin
      out_pc       = head_q.pc;
      out_instr    = head_q.instr;
      out_exc_en   = head_q.exc_en;
      out_exc_code = head_q.exc_code;
      out_exc_val  = head_q.exc_val;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit
// Model memory answers imem combinationally; expected entries are queued per redirect/reset.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;

  logic        fault_en = 1'b0;
  logic [63:0] fault_addr = 64'h2000;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ifetch_unit #(.RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_exc_en(out_exc_en),
    .out_exc_code(out_exc_code), .out_exc_val(out_exc_val)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'd0) return 32'h0010_0093;
    if (a == 64'd4) return 32'h0020_0113;
    return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  assign imem_instr    = mem_word(imem_addr);
  assign imem_exc_en   = fault_en && (imem_addr == fault_addr);
  assign imem_exc_code = imem_exc_en ? 4'd1 : 4'd0;
  assign imem_exc_val  = imem_exc_en ? imem_addr : 64'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ok(input logic [63:0] pc);
    exp_t e;
    e.pc = pc; e.instr = mem_word(pc); e.exc_en = 1'b0; e.exc_code = 4'd0; e.exc_val = 64'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_exc(input logic [63:0] pc, input logic [31:0] instr,
                          input logic [3:0] code, input logic [63:0] val);
    exp_t e;
    e.pc = pc; e.instr = instr; e.exc_en = 1'b1; e.exc_code = code; e.exc_val = val;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_redirect(input logic [63:0] target);
    exp_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  // Every accepted head is matched against the front of the scoreboard
  always @(negedge clk) begin
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      check("deq_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_pc", out_pc, mon_e.pc);
        check("out_instr", 64'(out_instr), 64'(mon_e.instr));
        check("out_exc_en", 64'(out_exc_en), 64'(mon_e.exc_en));
        check("out_exc_code", 64'(out_exc_code), 64'(mon_e.exc_code));
        check("out_exc_val", out_exc_val, mon_e.exc_val);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_instr", 64'(out_instr), 64'h13);
    check("rst_pc", out_pc, 64'd0);

    // Basic streaming from reset
    push_ok(64'd0); push_ok(64'd4); push_ok(64'd8);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("a_addr1", imem_addr, 64'd4);
    check("a_valid1", 64'(out_valid), 64'd1);
    step();
    check("a_addr2", imem_addr, 64'd8);
    drain("a");
    out_ready = 1'b0;

    // Backpressure: buffer saturates, head and PC hold
    do_redirect(64'd0);
    repeat (5) step();
    check("b_addr_held", imem_addr, 64'd8);
    check("b_pc_held", out_pc, 64'd0);
    check("b_valid", 64'(out_valid), 64'd1);
    push_ok(64'd0); push_ok(64'd4); push_ok(64'd8); push_ok(64'd12);
    out_ready = 1'b1;
    drain("b");
    out_ready = 1'b0;

    // Redirect while full and decode ready: flush wins over dequeue
    repeat (2) step();
    check("c_full_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    do_redirect(64'h40);
    check("c_flushed", 64'(out_valid), 64'd0);
    push_ok(64'h40); push_ok(64'h44);
    drain("c");
    out_ready = 1'b0;

    // Fetch fault at 0x2000 halts the unit
    fault_en = 1'b1;
    out_ready = 1'b1;
    do_redirect(64'h1FF8);
    push_ok(64'h1FF8); push_ok(64'h1FFC);
    push_exc(64'h2000, mem_word(64'h2000), 4'd1, 64'h2000);
    drain("d");
    repeat (4) step();
    check("d_addr_held", imem_addr, 64'h2000);
    check("d_idle", 64'(out_valid), 64'd0);
    fault_en = 1'b0;
    out_ready = 1'b0;

    // Misaligned redirect produces one faulting NOP entry
    do_redirect(64'h42);
    check("e_valid", 64'(out_valid), 64'd1);
    check("e_instr", 64'(out_instr), 64'h13);
    check("e_exc_val", out_exc_val, 64'h42);
    push_exc(64'h42, 32'h0000_0013, 4'd0, 64'h42);
    out_ready = 1'b1;
    drain("e");
    repeat (4) step();
    check("e_addr_held", imem_addr, 64'h42);
    check("e_idle", 64'(out_valid), 64'd0);

    // PC wraps past the top of the address space
    do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
    push_ok(64'hFFFF_FFFF_FFFF_FFF8); push_ok(64'hFFFF_FFFF_FFFF_FFFC);
    push_ok(64'd0); push_ok(64'd4);
    drain("f");
    out_ready = 1'b0;

    // Reset with a full buffer; redirect ignored during reset
    do_redirect(64'h100);
    repeat (3) step();
    check("g_full_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h300;
    step();
    check("g_rst_valid", 64'(out_valid), 64'd0);
    check("g_rst_addr", imem_addr, 64'd0);
    rst = 1'b0;
    redirect_valid = 1'b0;
    step();
    check("g_first_valid", 64'(out_valid), 64'd1);
    check("g_first_pc", out_pc, 64'd0);
    check("g_first_instr", 64'(out_instr), 64'h0010_0093);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
